// File: rtl/video_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_pkg : raster timing sets, colour-bar palette and RGB888 type  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package video_timing_pkg;

  typedef logic [23:0] rgb888_t;

  typedef enum logic [2:0] {
    BAR_WHITE   = 3'd0,
    BAR_YELLOW  = 3'd1,
    BAR_CYAN    = 3'd2,
    BAR_GREEN   = 3'd3,
    BAR_MAGENTA = 3'd4,
    BAR_RED     = 3'd5,
    BAR_BLUE    = 3'd6,
    BAR_BLACK   = 3'd7
  } bar_idx_e;

  localparam rgb888_t c_RGB_WHITE   = 24'hFFFFFF;
  localparam rgb888_t c_RGB_YELLOW  = 24'hFFFF00;
  localparam rgb888_t c_RGB_CYAN    = 24'h00FFFF;
  localparam rgb888_t c_RGB_GREEN   = 24'h00FF00;
  localparam rgb888_t c_RGB_MAGENTA = 24'hFF00FF;
  localparam rgb888_t c_RGB_RED     = 24'hFF0000;
  localparam rgb888_t c_RGB_BLUE    = 24'h0000FF;
  localparam rgb888_t c_RGB_BLACK   = 24'h000000;

  localparam int c_720P_H_ACTIVE  = 1280;
  localparam int c_720P_H_FP      = 110;
  localparam int c_720P_H_SYNC    = 40;
  localparam int c_720P_H_BP      = 220;
  localparam int c_720P_V_ACTIVE  = 720;
  localparam int c_720P_V_FP      = 5;
  localparam int c_720P_V_SYNC    = 5;
  localparam int c_720P_V_BP      = 20;

  localparam int c_1080P_H_ACTIVE = 1920;
  localparam int c_1080P_H_FP     = 88;
  localparam int c_1080P_H_SYNC   = 44;
  localparam int c_1080P_H_BP     = 148;
  localparam int c_1080P_V_ACTIVE = 1080;
  localparam int c_1080P_V_FP     = 4;
  localparam int c_1080P_V_SYNC   = 5;
  localparam int c_1080P_V_BP     = 36;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic rgb888_t bar_colour(input bar_idx_e idx);
    rgb888_t colour;
    case (idx)
      BAR_WHITE:   colour = c_RGB_WHITE;
      BAR_YELLOW:  colour = c_RGB_YELLOW;
      BAR_CYAN:    colour = c_RGB_CYAN;
      BAR_GREEN:   colour = c_RGB_GREEN;
      BAR_MAGENTA: colour = c_RGB_MAGENTA;
      BAR_RED:     colour = c_RGB_RED;
      BAR_BLUE:    colour = c_RGB_BLUE;
      default:     colour = c_RGB_BLACK;
    endcase
    return colour;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_out_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_out_if : pixel request/return and HDMI-side video signals     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface video_timing_out_if
  import video_timing_pkg::*;
#(
  parameter int H_WIDTH = 12,
  parameter int V_WIDTH = 11
);
  rgb888_t              pixel_data;
  logic                 pattern_en;
  logic                 pixel_req;
  logic [H_WIDTH-1:0]   x_pos;
  logic [V_WIDTH-1:0]   y_pos;
  rgb888_t              rgb_out;
  logic                 hsync;
  logic                 vsync;
  logic                 data_enable;
  logic                 frame_start;
  logic                 line_start;

  // master is the timing generator; slave is the upstream source plus transmitter
  modport master (
    input  pixel_data, pattern_en,
    output pixel_req, x_pos, y_pos, rgb_out, hsync, vsync,
           data_enable, frame_start, line_start
  );

  modport slave (
    output pixel_data, pattern_en,
    input  pixel_req, x_pos, y_pos, rgb_out, hsync, vsync,
           data_enable, frame_start, line_start
  );
endinterface
`default_nettype wire

// File: rtl/video_sync_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_sync_counter : h/v raster counters with active and raw sync decode   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module video_sync_counter
  import video_timing_pkg::*;
#(
  parameter int H_WIDTH  = 12,
  parameter int V_WIDTH  = 11,
  parameter int H_ACTIVE = c_720P_H_ACTIVE,
  parameter int H_FP     = c_720P_H_FP,
  parameter int H_SYNC   = c_720P_H_SYNC,
  parameter int H_BP     = c_720P_H_BP,
  parameter int V_ACTIVE = c_720P_V_ACTIVE,
  parameter int V_FP     = c_720P_V_FP,
  parameter int V_SYNC   = c_720P_V_SYNC,
  parameter int V_BP     = c_720P_V_BP
) (
  input  wire logic               clock,
  input  wire logic               reset,
  output logic                    o_active,
  output logic                    o_hs_raw,
  output logic                    o_vs_raw,
  output logic                    o_h_zero,
  output logic                    o_v_zero,
  output logic [H_WIDTH-1:0]      o_x_pos,
  output logic [V_WIDTH-1:0]      o_y_pos
);
  localparam logic [H_WIDTH-1:0] c_H_LAST     = H_WIDTH'(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [V_WIDTH-1:0] c_V_LAST     = V_WIDTH'(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [H_WIDTH-1:0] c_H_ACTIVE   = H_WIDTH'(H_ACTIVE);
  localparam logic [V_WIDTH-1:0] c_V_ACTIVE   = V_WIDTH'(V_ACTIVE);
  localparam logic [H_WIDTH-1:0] c_HS_FIRST   = H_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [H_WIDTH-1:0] c_HS_LAST    = H_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_WIDTH-1:0] c_VS_FIRST   = V_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [V_WIDTH-1:0] c_VS_LAST    = V_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [H_WIDTH-1:0] r_h_cnt;
  logic [V_WIDTH-1:0] r_v_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // vs_raw only depends on v_cnt, so it naturally changes on whole-line boundaries
  assign o_active = (r_h_cnt < c_H_ACTIVE) && (r_v_cnt < c_V_ACTIVE);
  assign o_hs_raw = (r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST);
  assign o_vs_raw = (r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST);
  assign o_h_zero = (r_h_cnt == '0);
  assign o_v_zero = (r_v_cnt == '0);
  assign o_x_pos  = o_active ? r_h_cnt : '0;
  assign o_y_pos  = o_active ? r_v_cnt : '0;

endmodule
`default_nettype wire

// File: rtl/video_timing_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_out : raster timing, pixel fetch pipeline and colour bars     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module video_timing_out
  import video_timing_pkg::*;
#(
  parameter int H_WIDTH  = 12,
  parameter int V_WIDTH  = 11,
  parameter int H_ACTIVE = c_720P_H_ACTIVE,
  parameter int H_FP     = c_720P_H_FP,
  parameter int H_SYNC   = c_720P_H_SYNC,
  parameter int H_BP     = c_720P_H_BP,
  parameter int V_ACTIVE = c_720P_V_ACTIVE,
  parameter int V_FP     = c_720P_V_FP,
  parameter int V_SYNC   = c_720P_V_SYNC,
  parameter int V_BP     = c_720P_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  wire logic          clock,
  input  wire logic          reset,
  video_timing_out_if.master bus
);
  logic               w_active;
  logic               w_hs_raw;
  logic               w_vs_raw;
  logic               w_h_zero;
  logic               w_v_zero;
  logic [H_WIDTH-1:0] w_x_pos;
  logic [V_WIDTH-1:0] w_y_pos;

  video_sync_counter #(
    .H_WIDTH  (H_WIDTH),
    .V_WIDTH  (V_WIDTH),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .o_active (w_active),
    .o_hs_raw (w_hs_raw),
    .o_vs_raw (w_vs_raw),
    .o_h_zero (w_h_zero),
    .o_v_zero (w_v_zero),
    .o_x_pos  (w_x_pos),
    .o_y_pos  (w_y_pos)
  );

  assign bus.pixel_req = w_active & ~reset;
  assign bus.x_pos     = w_x_pos;
  assign bus.y_pos     = w_y_pos;

  logic               r_s1_active;
  logic               r_s1_hs;
  logic               r_s1_vs;
  logic               r_s1_h0;
  logic               r_s1_v0;
  logic [H_WIDTH-1:0] r_s1_x;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_active <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_h0     <= 1'b0;
      r_s1_v0     <= 1'b0;
      r_s1_x      <= '0;
    end else begin
      r_s1_active <= w_active;
      r_s1_hs     <= w_hs_raw;
      r_s1_vs     <= w_vs_raw;
      r_s1_h0     <= w_h_zero;
      r_s1_v0     <= w_v_zero;
      r_s1_x      <= w_x_pos;
    end
  end

  // Bar k begins at ceil(k*H_ACTIVE/8); the ge flags form a thermometer code
  logic [7:1] w_bar_ge;
  bar_idx_e   w_bar_idx;
  rgb888_t    w_pix;

  for (genvar k = 1; k < 8; k++) begin : g_bar_bound
    localparam int c_BOUND = (k * H_ACTIVE + 7) / 8;
    assign w_bar_ge[k] = (r_s1_x >= H_WIDTH'(c_BOUND));
  end

  always_comb begin
    w_bar_idx = BAR_WHITE;
    for (int i = 1; i < 8; i++) begin
      if (w_bar_ge[i]) w_bar_idx = bar_idx_e'(3'(i));
    end
  end

  assign w_pix = !r_s1_active ? 24'h000000
               : (bus.pattern_en ? bar_colour(w_bar_idx) : bus.pixel_data);

  rgb888_t r_rgb;
  logic    r_de;
  logic    r_hsync;
  logic    r_vsync;
  logic    r_frame_start;
  logic    r_line_start;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rgb         <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_rgb         <= w_pix;
      r_de          <= r_s1_active;
      r_hsync       <= r_s1_hs ? HS_POL : ~HS_POL;
      r_vsync       <= r_s1_vs ? VS_POL : ~VS_POL;
      r_frame_start <= r_s1_active & r_s1_h0 & r_s1_v0;
      r_line_start  <= r_s1_active & r_s1_h0;
    end
  end

  assign bus.rgb_out     = r_rgb;
  assign bus.data_enable = r_de;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.frame_start = r_frame_start;
  assign bus.line_start  = r_line_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_timing_out : scoreboard bench, small raster plus a 720p instance  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_video_timing_out;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;

  logic clock = 1'b0;
  logic reset;
  logic reset_hd;

  always #5 clock = ~clock;

  video_timing_out_if #(.H_WIDTH(12), .V_WIDTH(11)) vif ();
  video_timing_out_if #(.H_WIDTH(12), .V_WIDTH(11)) vif_hd ();

  video_timing_out #(
    .H_WIDTH(12), .V_WIDTH(11),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif)
  );

  video_timing_out dut_hd (
    .clock (clock),
    .reset (reset_hd),
    .bus   (vif_hd)
  );

  typedef struct {
    logic        req;
    logic [11:0] x;
    logic [10:0] y;
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        ls;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  bit cnt_en = 0;
  int cnt_req = 0, cnt_de = 0, cnt_fs = 0, cnt_ls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_ref(input int x, input int ha);
    logic [23:0] c;
    case (x * 8 / ha)
      0: c = 24'hFFFFFF;
      1: c = 24'hFFFF00;
      2: c = 24'h00FFFF;
      3: c = 24'h00FF00;
      4: c = 24'hFF00FF;
      5: c = 24'hFF0000;
      6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Reference history: reset/position of the last two cycles and the data/pattern of the last one
  bit          rst1 = 1, rst2 = 1;
  int          pos1 = 0, pos2 = 0;
  bit          req1 = 0;
  bit          pat1 = 0;
  logic [23:0] data1 = '0;

  task automatic step(input bit r, input bit p);
    int          pos, h, v, h2, v2;
    bit          act, act2;
    logic [23:0] d;
    exp_t        e;
    @(posedge clock);
    #1;
    pos = rst1 ? 0 : (pos1 + 1) % FT;
    if (req1) d = {8'($urandom), 8'(pos1 / HT), 8'(pos1 % HT)};
    else      d = 24'($urandom);
    reset          = r;
    vif.pattern_en = p;
    vif.pixel_data = d;

    h   = pos % HT;
    v   = pos / HT;
    act = (h < HA) && (v < VA);
    e.req = act && !r;
    e.x   = act ? 12'(h) : 12'd0;
    e.y   = act ? 11'(v) : 11'd0;

    // Outputs show the position requested two cycles ago unless reset hit either edge since
    if (rst1 || rst2) begin
      e.rgb = '0; e.de = 0; e.hs = ~HSP; e.vs = ~VSP; e.fs = 0; e.ls = 0;
    end else begin
      h2   = pos2 % HT;
      v2   = pos2 / HT;
      act2 = (h2 < HA) && (v2 < VA);
      e.de  = act2;
      e.rgb = act2 ? (pat1 ? bar_ref(h2, HA) : data1) : 24'h000000;
      e.hs  = (h2 >= HA + HFP && h2 < HA + HFP + HSW) ? HSP : ~HSP;
      e.vs  = (v2 >= VA + VFP && v2 < VA + VFP + VSW) ? VSP : ~VSP;
      e.fs  = act2 && h2 == 0 && v2 == 0;
      e.ls  = act2 && h2 == 0;
    end
    sb_q.push_back(e);

    rst2 = rst1; rst1 = r;
    pos2 = pos1; pos1 = pos;
    req1 = e.req; pat1 = p; data1 = d;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pixel_req",   32'(vif.pixel_req),   32'(e.req));
        chk("x_pos",       32'(vif.x_pos),       32'(e.x));
        chk("y_pos",       32'(vif.y_pos),       32'(e.y));
        chk("rgb_out",     32'(vif.rgb_out),     32'(e.rgb));
        chk("data_enable", 32'(vif.data_enable), 32'(e.de));
        chk("hsync",       32'(vif.hsync),       32'(e.hs));
        chk("vsync",       32'(vif.vsync),       32'(e.vs));
        chk("frame_start", 32'(vif.frame_start), 32'(e.fs));
        chk("line_start",  32'(vif.line_start),  32'(e.ls));
      end
      if (cnt_en) begin
        cnt_req += int'(vif.pixel_req);
        cnt_de  += int'(vif.data_enable);
        cnt_fs  += int'(vif.frame_start);
        cnt_ls  += int'(vif.line_start);
      end
    end
  end

  initial begin
    reset = 1'b1;
    reset_hd = 1'b1;
    vif.pattern_en = 1'b0;
    vif.pixel_data = '0;
    fork
      begin : small_flow
        repeat (3) step(1, 0);
        step(0, 0);
        cnt_en = 1;
        repeat (255) step(0, 0);
        @(negedge clock);
        #1 cnt_en = 0;
        chk("req_per_2frames",  32'(cnt_req), 32'd64);
        chk("de_per_2frames",   32'(cnt_de),  32'd64);
        chk("fs_per_2frames",   32'(cnt_fs),  32'd2);
        chk("ls_per_2frames",   32'(cnt_ls),  32'd8);

        repeat (FT) step(0, 1);
        repeat (FT) step(0, 1'($urandom));

        for (int i = 0; i < FT && !(pos1 == 36 && !rst1); i++) step(0, 1'($urandom));
        step(1, 0);
        repeat (140) step(0, 0);

        repeat (300) step(($urandom_range(0, 49) == 0), 1'($urandom));
        repeat (4) step(0, 0);
      end
      begin : hd_flow
        int de_cnt, hs_cnt, vs_cnt, req_cnt, fs_cnt, ls_cnt, first_de, first_rise;
        bit hs_prev;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; req_cnt = 0; fs_cnt = 0; ls_cnt = 0;
        first_de = -1; first_rise = -1; hs_prev = 0;
        vif_hd.pattern_en = 1'b1;
        vif_hd.pixel_data = 24'h5A5A5A;
        repeat (3) @(posedge clock);
        #1 reset_hd = 1'b0;
        for (int c = 0; c < 3 * 1650; c++) begin
          @(negedge clock);
          req_cnt += int'(vif_hd.pixel_req);
          fs_cnt  += int'(vif_hd.frame_start);
          ls_cnt  += int'(vif_hd.line_start);
          vs_cnt  += int'(vif_hd.vsync);
          hs_cnt  += int'(vif_hd.hsync);
          if (vif_hd.data_enable) begin
            de_cnt++;
            if (first_de < 0) first_de = c;
            if (c < 1650) chk("hd_bar", 32'(vif_hd.rgb_out), 32'(bar_ref(c - 2, 1280)));
          end
          if (vif_hd.hsync && !hs_prev && first_rise < 0) first_rise = c;
          hs_prev = vif_hd.hsync;
        end
        chk("hd_first_de",      32'(first_de),            32'd2);
        chk("hd_hsync_offset",  32'(first_rise - first_de), 32'd1390);
        chk("hd_hsync_cycles",  32'(hs_cnt),              32'd120);
        chk("hd_de_cycles",     32'(de_cnt),              32'd3840);
        chk("hd_req_cycles",    32'(req_cnt),             32'd3840);
        chk("hd_vsync_cycles",  32'(vs_cnt),              32'd0);
        chk("hd_frame_start",   32'(fs_cnt),              32'd1);
        chk("hd_line_start",    32'(ls_cnt),              32'd3);
      end
    join
    @(negedge clock);
    #1;
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
